mul_share_arbiter: RTL
======================

# mul_share_arbiter

Shares one combinational 8x8 unsigned multiplier between `NUM_REQ` requesters. Each requester has a valid/ready operand channel. A round-robin arbiter picks one requester per cycle and registers its operands in front of the multiplier. The product, tagged with the requester index, is registered and presented on a single valid/ready response channel. The block sits between client engines and the shared multiplier datapath, and throughput is one product per cycle when downstream never stalls.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag. Derived; do not override.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, `NUM_REQ`: per-requester operand valid.
- `req_ready`, output, `NUM_REQ`: per-requester accept. At most one bit is high in any cycle.
- `req_a`, input, `NUM_REQ*8`: operand A. Requester i drives bits [8i+7:8i].
- `req_b`, input, `NUM_REQ*8`: operand B. Same packing as `req_a`.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: downstream accept.
- `rsp_id`, output, `ID_W`: index of the requester that owns `rsp_product`.
- `rsp_product`, output, 16: unsigned product a*b, full width, no truncation.
- `busy`, output, 1: high while any pipeline stage is occupied.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. Requesters hold `req_valid`, `req_a` and `req_b` stable until accepted. `rsp_*` stays stable while `rsp_valid=1` and `rsp_ready=0`.
- Stage S1, operand register: fields `s1_v`, `s1_a`, `s1_b`, `s1_id`.
- Stage S2, product register: fields `s2_v`, `s2_p`, `s2_id`. Outputs are `rsp_valid=s2_v`, `rsp_product=s2_p`, `rsp_id=s2_id`.
- Advance rule: `s2_free = !s2_v | rsp_ready`, and `s1_free = !s1_v | s2_free`.
- S1 to S2: when `s2_free`, load S2 from S1. `s2_p` is `s1_a*s1_b` from the multiplier, and `s2_v` takes `s1_v`.
- Arbiter to S1: when `s1_free`, grant goes to the first requester with `req_valid` high, searching from `ptr+1` upward modulo `NUM_REQ`.
  - `req_ready[g]=1` for the granted index only.
  - S1 loads that requester's operands and `s1_v=1`.
  - If nothing is granted, `s1_v` takes 0 (only when `s1_free`).
- `req_ready` is combinational from `req_valid`, `ptr`, `s1_v`, `s2_v` and `rsp_ready`. There is no combinational path from `req_a` or `req_b` to any output.
- Pointer: `ptr` updates to the granted index only on an accepted grant, otherwise it holds. Reset value is `NUM_REQ-1`, so requester 0 has first priority.
- Fairness: a continuously requesting client waits at most `NUM_REQ-1` grants.
- Simultaneous events:
  - With S2 draining, S1 advancing and a new grant in the same cycle, all three happen; no bubble is inserted.
  - With `rsp_ready=0` and both stages full, every `req_ready` is 0.
- `busy = s1_v | s2_v`.
- Reset, at any time including mid-transfer:
  - `s1_v=0`, `s2_v=0`, `ptr=NUM_REQ-1`.
  - `rsp_valid=0`, `rsp_product=0`, `rsp_id=0`, `busy=0`, `req_ready=0` while `rst_n=0`.
  - In-flight operations are dropped and no response is emitted for them.
- Arithmetic: unsigned only. 255*255 gives 16'hFE01. 0*x gives 0.

## Timing
- Latency: a request accepted at edge N gives `rsp_valid=1` after edge N+1, which is 2 cycles from `req_valid` to `rsp_valid` with no stall.
- Throughput: 1 accept per cycle while `rsp_ready=1`.
- Capacity: 2 operations in flight. Under a sustained stall exactly 2 are accepted, then `req_ready` drops to 0.
- After a stall, the first `rsp_ready=1` cycle re-enables a grant in that same cycle.
- The first grant is possible on the first edge after `rst_n` deasserts.

## Structure
- Shared package `mul_pkg`:
  - `MUL_OP_W=8`, `MUL_PROD_W=16`.
  - Type `mul_op_t`, a packed struct {a, b, id}.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`.
  - Inputs: request vector, `ptr` and an enable.
  - Outputs: one-hot grant and the encoded index.
  - Purely combinational; `ptr` is owned by the parent.
- The multiplier is the team's existing combinational 8x8 multiplier, instantiated once between S1 and S2.

## Test plan
- Single request: req0 sends a=3, b=5, `rsp_ready=1` → `rsp_valid` two cycles later with product 15, id 0; `busy` high for exactly 2 cycles.
- All four requesters valid from reset, each with a=i+1, b=10 → grants in order 0,1,2,3 on consecutive cycles; responses 10,20,30,40 with ids 0..3 on consecutive cycles.
- Backpressure: four requests while `rsp_ready=0` for 6 cycles → only 2 accepted, `rsp_*` held stable; after release the remaining 2 are accepted with no loss or reordering.
- Fairness: req0 and req2 permanently valid → grants alternate 0,2,0,2; req1 and req3 never granted.
- Corner operands: a=255, b=255 gives 16'hFE01; a=0, b=200 gives 0; a=1, b=255 gives 255.
- Reset mid-operation: assert `rst_n=0` with both stages full → all outputs 0 immediately; after release, req3 alone is granted on the first edge and its response is correct, with no stale response emitted.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths and operand record for the shared multiplier
package mul_pkg;

  localparam int MUL_OP_W   = 8;
  localparam int MUL_PROD_W = 16;
  // Wide enough for the largest legal requester count (8).
  localparam int MUL_ID_W   = 3;

  typedef struct packed {
    logic [MUL_OP_W-1:0] a;
    logic [MUL_OP_W-1:0] b;
    logic [MUL_ID_W-1:0] id;
  } mul_op_t;

endpackage

// File: rtl/mul8x8.sv
// rtl/mul8x8.sv - combinational 8x8 unsigned multiplier
module mul8x8
  import mul_pkg::*;
(
  input  logic [MUL_OP_W-1:0]   a,
  input  logic [MUL_OP_W-1:0]   b,
  output logic [MUL_PROD_W-1:0] p
);

  // Zero-extend both operands so the full 16-bit product is kept.
  assign p = {{(MUL_PROD_W-MUL_OP_W){1'b0}}, a} * {{(MUL_PROD_W-MUL_OP_W){1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  // First requester found scanning ptr+1, ptr+2, ... modulo NUM_REQ wins.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one 8x8 multiplier, two-stage pipeline
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MUL_OP_W-1:0]  req_a,
  input  logic [NUM_REQ*MUL_OP_W-1:0]  req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [MUL_PROD_W-1:0]        rsp_product,
  output logic                         busy
);

  logic                  s1_v;
  mul_op_t               s1;
  logic                  s2_v;
  logic [MUL_PROD_W-1:0] s2_p;
  logic [MUL_ID_W-1:0]   s2_id;
  logic [ID_W-1:0]       ptr;

  logic                  s2_free;
  logic                  s1_free;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_valid;
  logic [MUL_OP_W-1:0]   sel_a;
  logic [MUL_OP_W-1:0]   sel_b;
  logic [MUL_PROD_W-1:0] prod;
  logic                  unused_id_bits;

  assign s2_free = !s2_v || rsp_ready;
  assign s1_free = !s1_v || s2_free;
  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign arb_en  = s1_free && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .en          (arb_en),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  // Operand select for the granted requester; only feeds S1, never an output.
  always_comb begin
    sel_a = req_a[int'(grant_id)*MUL_OP_W +: MUL_OP_W];
    sel_b = req_b[int'(grant_id)*MUL_OP_W +: MUL_OP_W];
  end

  mul8x8 u_mul (
    .a (s1.a),
    .b (s1.b),
    .p (prod)
  );

  // S1 operand register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1   <= '0;
      ptr  <= ID_W'(NUM_REQ - 1);
    end else if (s1_free) begin
      s1_v <= grant_valid;
      if (grant_valid) begin
        s1.a  <= sel_a;
        s1.b  <= sel_b;
        s1.id <= MUL_ID_W'(grant_id);
        ptr   <= grant_id;
      end
    end
  end

  // S2 product register, advances whenever the response slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_p  <= '0;
      s2_id <= '0;
    end else if (s2_free) begin
      s2_v  <= s1_v;
      s2_p  <= prod;
      s2_id <= s1.id;
    end
  end

  assign rsp_valid      = s2_v;
  assign rsp_product    = s2_p;
  assign rsp_id         = s2_id[ID_W-1:0];
  assign busy           = s1_v || s2_v;
  assign unused_id_bits = ^s2_id;

endmodule
